memory_access: RTL and testbench
================================

# memory_access

Y86 memory stage, sitting directly downstream of `execute`. It consumes `valE`/`valA` from execute and `valP` from fetch, and performs the single data-memory read or write each instruction requires. It returns a registered `valM` to write-back and maintains the sticky processor status (`stat`), which halts all further memory side effects after HLT or any error.

## Interface
Parameters:
- `DMEM_BYTES`, default 1024: data memory size in bytes, byte-addressed, starting at address 0.

Ports:
- `clk_i`, in, 1: clock. All state updates on the rising edge.
- `rst_n_i`, in, 1: synchronous, active-low reset.
- `valid_i`, in, 1: an instruction is presented this cycle.
- `icode_i`, in, 4: instruction code.
- `instr_valid_i`, in, 1: fetch decoded a legal icode.
- `imem_error_i`, in, 1: fetch address error.
- `valE_i`, in, 64: ALU result from execute.
- `valA_i`, in, 64: decode operand A.
- `valP_i`, in, 64: next-PC value from fetch.
- `valM_o`, out, 64: data read from memory (registered).
- `valid_o`, out, 1: `valM_o`, `stat_o` and `dmem_error_o` correspond to the instruction accepted last cycle.
- `dmem_error_o`, out, 1: that access was out of range (or misaligned when configured).
- `stat_o`, out, 3: status code. AOK=1, HLT=2, ADR=3, INS=4.
- `halted_o`, out, 1: sticky; the stage has stopped accepting instructions.

## Operation
- Accept rule: an instruction is accepted when `valid_i` is 1 and `halted_o` is 0. Otherwise the cycle is a no-op: no write occurs and `valid_o` is 0 on the next cycle.
- Address and data by icode:
  - RMMOVL (4): write `valA` to address `valE`.
  - PUSHL (A): write `valA` to address `valE`.
  - CALL (8): write `valP` to address `valE`.
  - MRMOVL (5): read from address `valE`.
  - POPL (B): read from address `valA`.
  - RET (9): read from address `valA`.
  - All other icodes: no access, and `valM_o` is 0.
- Every access is 8 bytes, little-endian. Bytes `addr..addr+7` map to bits `[7:0]..[63:56]`.
- Range check:
  - The check is `addr > DMEM_BYTES-8`, an unsigned 64-bit compare. This form avoids `addr+7` overflow; addresses near 2^64 must flag the error, not wrap.
  - An out-of-range write does not modify memory. An out-of-range read returns `valM_o` = 0.
- Status of an accepted instruction, in priority order:
  1. `imem_error_i` or dmem error gives ADR.
  2. Otherwise `!instr_valid_i` gives INS.
  3. Otherwise icode HALT (1) gives HLT.
  4. Otherwise AOK.
- Write suppression: any accepted instruction with non-AOK status performs no write.
- Sticky halt: a non-AOK status sets `halted_o` = 1 and freezes `stat_o` at that code until reset.
- Memory array contents are not cleared by reset. The bench preloads them hierarchically via array `data_mem` inside the submodule.

## Timing
- Reset values: `valM_o` = 0, `valid_o` = 0, `dmem_error_o` = 0, `stat_o` = 1 (AOK), `halted_o` = 0.
- Latency is one cycle. For an instruction accepted at edge N:
  - its write commits at edge N;
  - `valM_o`, `stat_o`, `dmem_error_o` and `valid_o` = 1 are visible after edge N, for one cycle.
- Throughput: one instruction per cycle, with no backpressure.
- Read after write: a read accepted at edge N+1 observes a write committed at edge N.
- While `valid_o` is 0, `valM_o` and `dmem_error_o` hold their last values. `stat_o` always shows the current status.
- Reset mid-operation: reset has priority. The instruction at that edge performs no write, and all outputs return to their reset values.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: an access whose `addr[2:0] != 0` also raises `dmem_error_o` and status ADR. The write is suppressed and the read returns 0.
- `MEM_ALIGN_CHECK_EN` undefined: unaligned accesses are legal and are subject only to the range check.

## Structure
- Shared package `y86_pkg` holds:
  - the icode constants (NOP..POPL);
  - the stat codes (`STAT_AOK`=1, `STAT_HLT`=2, `STAT_ADR`=3, `STAT_INS`=4).
- Sub-module `data_memory`:
  - byte array `data_mem[0:DMEM_BYTES-1]`;
  - 64-bit combinational little-endian read;
  - 64-bit synchronous write with a write enable;
  - range/alignment error output.
- The top level holds the address/data muxes, the status priority logic, and the output and sticky registers.

## Test plan
- Reset: hold `rst_n_i` = 0 for 3 cycles → all outputs at their reset values; `stat_o` = 1.
- RMMOVL: `valE` = 0x10, `valA` = 0x1122334455667788. Then MRMOVL with `valE` = 0x10 → `valM_o` = 0x1122334455667788 with `valid_o` = 1 one cycle later, and `data_mem[0x10]` = 0x88.
- CALL: `valE` = 0x100, `valP` = 0x2A. Next cycle RET with `valA` = 0x100 → `valM_o` = 0x2A, `stat_o` = AOK.
- MRMOVL with `valE` = 0xFFFFFFFFFFFFFFFC → `dmem_error_o` = 1, `stat_o` = 3, `halted_o` = 1. A subsequent RMMOVL to 0x20 leaves `data_mem[0x20]` unchanged and `valid_o` = 0.
- HALT (icode 1) → `stat_o` = 2 and `halted_o` = 1. Then `instr_valid_i` = 0 with `imem_error_i` = 1 in a fresh run → `stat_o` = 3 (ADR beats INS).
- With `MEM_ALIGN_CHECK_EN` defined: RMMOVL to 0x13 → `dmem_error_o` = 1, no write. Without the macro, the same access writes bytes 0x13..0x1A.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes and the processor status encoding.
package y86_pkg;

  localparam logic [3:0] ICODE_NOP    = 4'h0;
  localparam logic [3:0] ICODE_HALT   = 4'h1;
  localparam logic [3:0] ICODE_RRMOVL = 4'h2;
  localparam logic [3:0] ICODE_IRMOVL = 4'h3;
  localparam logic [3:0] ICODE_RMMOVL = 4'h4;
  localparam logic [3:0] ICODE_MRMOVL = 4'h5;
  localparam logic [3:0] ICODE_OPL    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHL  = 4'hA;
  localparam logic [3:0] ICODE_POPL   = 4'hB;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  // Number of bytes moved by every data-memory access.
  localparam int unsigned ACCESS_BYTES = 8;

endpackage

// File: rtl/data_memory.sv
// Byte-addressed Y86 data memory: 64-bit little-endian combinational read, synchronous write.
// Optional MEM_ALIGN_CHECK_EN also flags accesses whose address is not 8-byte aligned.
module data_memory
  import y86_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic [63:0] addr_i,
  input  logic        access_i,
  input  logic        we_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] rdata_o,
  output logic        error_o
);

  localparam int unsigned AW = (DMEM_BYTES > 1) ? $clog2(DMEM_BYTES) : 1;
  // Highest legal base address; comparing against it avoids addr+7 wrapping near 2^64.
  localparam logic [63:0] LAST_BASE = 64'(DMEM_BYTES - ACCESS_BYTES);

  logic [7:0]    data_mem [0:DMEM_BYTES-1];
  logic          range_err_s;
  logic          align_err_s;
  logic [AW-1:0] base_s;

  // Range/alignment check and a clamped base index so out-of-range reads never index past the array.
  always_comb begin
    range_err_s = (addr_i > LAST_BASE);
`ifdef MEM_ALIGN_CHECK_EN
    align_err_s = (addr_i[2:0] != 3'd0);
`else
    align_err_s = 1'b0;
`endif
    error_o = access_i && (range_err_s || align_err_s);
    if (range_err_s) begin
      base_s = {AW{1'b0}};
    end else begin
      base_s = addr_i[AW-1:0];
    end
  end

  // Little-endian read assembly; an erroring access returns zero.
  always_comb begin
    rdata_o = 64'd0;
    if (!error_o) begin
      for (int k = 0; k < 8; k++) begin
        rdata_o[8*k +: 8] = data_mem[base_s + AW'(k)];
      end
    end else begin
      rdata_o = 64'd0;
    end
  end

  // Byte-lane write; the array is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i && !error_o) begin
      for (int k = 0; k < 8; k++) begin
        data_mem[base_s + AW'(k)] <= wdata_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_access.sv
// Y86 memory stage: address/data select, status priority, registered valM and sticky halt.
// Optional MEM_ALIGN_CHECK_EN (handled in data_memory) turns misaligned accesses into ADR.
module memory_access
  import y86_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  input  logic [3:0]  icode_i,
  input  logic        instr_valid_i,
  input  logic        imem_error_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valP_i,
  output logic [63:0] valM_o,
  output logic        valid_o,
  output logic        dmem_error_o,
  output logic [2:0]  stat_o,
  output logic        halted_o
);

  logic        accept_s;
  logic        is_write_s;
  logic        is_read_s;
  logic [63:0] mem_addr_s;
  logic [63:0] wdata_s;
  logic [63:0] rdata_s;
  logic        dmem_err_s;
  logic        we_s;
  stat_e       stat_new_s;

  logic [63:0] valm_d, valm_q;
  logic        valid_d, valid_q;
  logic        dmem_err_d, dmem_err_q;
  stat_e       stat_d, stat_q;
  logic        halted_d, halted_q;

  // Per-icode address and write-data selection.
  always_comb begin
    is_write_s = 1'b0;
    is_read_s  = 1'b0;
    mem_addr_s = 64'd0;
    wdata_s    = 64'd0;
    case (icode_i)
      ICODE_RMMOVL, ICODE_PUSHL: begin
        is_write_s = 1'b1;
        mem_addr_s = valE_i;
        wdata_s    = valA_i;
      end
      ICODE_CALL: begin
        is_write_s = 1'b1;
        mem_addr_s = valE_i;
        wdata_s    = valP_i;
      end
      ICODE_MRMOVL: begin
        is_read_s  = 1'b1;
        mem_addr_s = valE_i;
      end
      ICODE_POPL, ICODE_RET: begin
        is_read_s  = 1'b1;
        mem_addr_s = valA_i;
      end
      default: begin
        is_write_s = 1'b0;
        is_read_s  = 1'b0;
      end
    endcase
  end

  // Status priority: address faults beat illegal instructions, which beat HALT.
  always_comb begin
    stat_new_s = STAT_AOK;
    if (imem_error_i || dmem_err_s) begin
      stat_new_s = STAT_ADR;
    end else if (!instr_valid_i) begin
      stat_new_s = STAT_INS;
    end else if (icode_i == ICODE_HALT) begin
      stat_new_s = STAT_HLT;
    end else begin
      stat_new_s = STAT_AOK;
    end
  end

  assign accept_s = valid_i && !halted_q;
  // Reset at the same edge must also squash the write.
  assign we_s     = rst_n_i && accept_s && is_write_s && (stat_new_s == STAT_AOK);

  data_memory #(
    .DMEM_BYTES(DMEM_BYTES)
  ) u_dmem (
    .clk_i    (clk_i),
    .addr_i   (mem_addr_s),
    .access_i (is_write_s || is_read_s),
    .we_i     (we_s),
    .wdata_i  (wdata_s),
    .rdata_o  (rdata_s),
    .error_o  (dmem_err_s)
  );

  // Next-state for output and sticky registers; unaccepted cycles hold everything.
  always_comb begin
    valm_d     = valm_q;
    valid_d    = 1'b0;
    dmem_err_d = dmem_err_q;
    stat_d     = stat_q;
    halted_d   = halted_q;
    if (accept_s) begin
      valid_d    = 1'b1;
      dmem_err_d = dmem_err_s;
      stat_d     = stat_new_s;
      halted_d   = (stat_new_s != STAT_AOK);
      if (is_read_s && !dmem_err_s) begin
        valm_d = rdata_s;
      end else begin
        valm_d = 64'd0;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Output and sticky-state registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valm_q     <= 64'd0;
      valid_q    <= 1'b0;
      dmem_err_q <= 1'b0;
      stat_q     <= STAT_AOK;
      halted_q   <= 1'b0;
    end else begin
      valm_q     <= valm_d;
      valid_q    <= valid_d;
      dmem_err_q <= dmem_err_d;
      stat_q     <= stat_d;
      halted_q   <= halted_d;
    end
  end

  assign valM_o       = valm_q;
  assign valid_o      = valid_q;
  assign dmem_error_o = dmem_err_q;
  assign stat_o       = stat_q;
  assign halted_o     = halted_q;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: byte-array reference model, per-cycle expectation queue.
module tb_memory_access;

  localparam int unsigned N = 1024;
  localparam logic [63:0] LAST = 64'(N - 8);
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, valid, iv, ie;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic [63:0] valM_o;
  logic        valid_o, dmem_error_o, halted_o;
  logic [2:0]  stat_o;

  always #5 clk = ~clk;

  memory_access #(.DMEM_BYTES(N)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .icode_i(icode),
    .instr_valid_i(iv), .imem_error_i(ie), .valE_i(valE), .valA_i(valA), .valP_i(valP),
    .valM_o(valM_o), .valid_o(valid_o), .dmem_error_o(dmem_error_o),
    .stat_o(stat_o), .halted_o(halted_o)
  );

  typedef struct {
    logic        v;
    logic [63:0] m;
    logic        e;
    logic [2:0]  s;
    logic        h;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  mem_m [0:N-1];
  logic        m_halted;
  logic [2:0]  m_stat;
  logic [63:0] m_valm;
  logic        m_derr;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: each negedge compares what the last posedge produced with the oldest expectation.
  always begin
    @(negedge clk);
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("valid_o", {63'd0, valid_o}, {63'd0, mon_e.v});
      chk("valM_o", valM_o, mon_e.m);
      chk("dmem_error_o", {63'd0, dmem_error_o}, {63'd0, mon_e.e});
      chk("stat_o", {61'd0, stat_o}, {61'd0, mon_e.s});
      chk("halted_o", {63'd0, halted_o}, {63'd0, mon_e.h});
    end
  end

  // Drive one cycle of stimulus and push the reference model's expectation for the coming edge.
  task automatic step(input logic r, input logic v, input logic [3:0] ic, input logic iv_,
                      input logic ie_, input logic [63:0] e, input logic [63:0] a, input logic [63:0] p);
    exp_t        x;
    logic        wr, rd, de;
    logic [63:0] addr, data, rv;
    logic [2:0]  st;
    @(negedge clk);
    #1;
    rst_n = r; valid = v; icode = ic; iv = iv_; ie = ie_; valE = e; valA = a; valP = p;
    if (!r) begin
      m_halted = 1'b0; m_stat = 3'd1; m_valm = 64'd0; m_derr = 1'b0;
      x.v = 1'b0;
    end else if (v && !m_halted) begin
      wr   = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
      rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
      addr = ((ic == 4'h9) || (ic == 4'hB)) ? a : e;
      data = (ic == 4'h8) ? p : a;
      de   = (wr || rd) && ((addr > LAST) || (ALIGN && (addr[2:0] != 3'd0)));
      if (ie_ || de)            st = 3'd3;
      else if (!iv_)            st = 3'd4;
      else if (ic == 4'h1)      st = 3'd2;
      else                      st = 3'd1;
      rv = 64'd0;
      if (rd && !de) for (int k = 0; k < 8; k++) rv[8*k +: 8] = mem_m[addr + 64'(k)];
      if (wr && st == 3'd1) for (int k = 0; k < 8; k++) mem_m[addr + 64'(k)] = data[8*k +: 8];
      m_valm = rv; m_derr = de; m_stat = st;
      if (st != 3'd1) m_halted = 1'b1;
      x.v = 1'b1;
    end else begin
      x.v = 1'b0;
    end
    x.m = m_valm; x.e = m_derr; x.s = m_stat; x.h = m_halted;
    exp_q.push_back(x);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
  endtask

  task automatic instr(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a, input logic [63:0] p);
    step(1'b1, 1'b1, ic, 1'b1, 1'b0, e, a, p);
  endtask

  // Compare a DUT memory byte against the model; the idle cycle lets the last write land first.
  task automatic mem_chk(input int unsigned addr);
    idle();
    chk("data_mem", {56'd0, dut.u_dmem.data_mem[addr]}, {56'd0, mem_m[addr]});
  endtask

  function automatic logic [63:0] gen_addr();
    logic [63:0] x;
    logic [4:0]  w;
    case ($urandom % 8)
      0, 1, 2, 3, 4: begin w = 5'($urandom_range(0, 31)); x = {56'd0, w, 3'b000}; end
      5:             x = 64'($urandom_range(0, N - 1));
      6:             x = 64'($urandom_range(N - 12, N - 4));
      default:       x = {32'hFFFF_FFFF, $urandom};
    endcase
    return x;
  endfunction

  initial begin
    logic [7:0]  b;
    logic [3:0]  ic;
    logic        iv_, ie_;
    logic [63:0] a;
    rst_n = 1'b0; valid = 1'b0; icode = 4'h0; iv = 1'b1; ie = 1'b0;
    valE = 64'd0; valA = 64'd0; valP = 64'd0;
    m_halted = 1'b0; m_stat = 3'd1; m_valm = 64'd0; m_derr = 1'b0;
    for (int i = 0; i < N; i++) begin
      b = 8'($urandom);
      mem_m[i] = b;
      dut.u_dmem.data_mem[i] <= b;
    end

    do_reset(3);

    instr(4'h4, 64'h10, 64'h1122334455667788, 64'd0);
    instr(4'h5, 64'h10, 64'd0, 64'd0);
    idle();
    chk("data_mem_0x10", {56'd0, dut.u_dmem.data_mem[16]}, 64'h88);

    instr(4'h8, 64'h100, 64'h0, 64'h2A);
    instr(4'h9, 64'h0, 64'h100, 64'h0);
    instr(4'hA, 64'h200, 64'hDEAD_BEEF_0BAD_F00D, 64'h0);
    instr(4'hB, 64'h0, 64'h200, 64'h0);
    instr(4'h5, LAST, 64'd0, 64'd0);
    instr(4'h6, 64'h55, 64'h66, 64'h77);

    instr(4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0);
    instr(4'h4, 64'h20, 64'hA5A5_A5A5_A5A5_A5A5, 64'd0);
    mem_chk(32'h20);
    do_reset(2);

    instr(4'h4, LAST + 64'd1, 64'h1234, 64'd0);
    mem_chk(N - 7);
    do_reset(2);

    instr(4'h1, 64'd0, 64'd0, 64'd0);
    instr(4'h0, 64'd0, 64'd0, 64'd0);
    do_reset(2);
    step(1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 64'd0, 64'd0, 64'd0);
    do_reset(2);
    step(1'b1, 1'b1, 4'hE, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    do_reset(2);

    instr(4'h4, 64'h13, 64'h0102_0304_0506_0708, 64'd0);
    for (int i = 8'h13; i <= 8'h1A; i++) mem_chk(i);
    do_reset(2);

    step(1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 64'h40, 64'hFFFF_0000_FFFF_0000, 64'd0);
    mem_chk(32'h40);

    for (int n = 0; n < 3000; n++) begin
      if ((m_halted && ($urandom % 4) == 0) || ($urandom % 100) == 0) begin
        step(1'b0, ($urandom % 2) == 0, 4'h4, 1'b1, 1'b0, gen_addr(), {$urandom, $urandom}, 64'd0);
      end else begin
        ic = 4'($urandom_range(0, 11));
        if (ic == 4'h1 && ($urandom % 4) != 0) ic = 4'h5;
        iv_ = ($urandom % 40) != 0;
        if (!iv_) ic = 4'($urandom_range(0, 15));
        ie_ = ($urandom % 50) == 0;
        a = ((ic == 4'h9) || (ic == 4'hB)) ? gen_addr() : {$urandom, $urandom};
        step(1'b1, ($urandom % 8) != 0, ic, iv_, ie_, gen_addr(), a, {$urandom, $urandom});
      end
    end

    idle();
    idle();
    for (int i = 0; i < N; i++) chk("final_mem", {56'd0, dut.u_dmem.data_mem[i]}, {56'd0, mem_m[i]});
    @(negedge clk);
    #2;
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
